// File: rtl/axil_rd_arbiter_if.sv
// AXI4-lite read-channel bundle (AR + R) carrying N ports side by side.
// Port i occupies araddr[i*ADDR_WIDTH +: ADDR_WIDTH] and arprot[i*3 +: 3];
// rdata/rresp are shared by all ports, valid/ready are one bit per port.
//
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; a source that raised valid keeps it
// and its payload stable until that edge, and ready may depend on valid.
interface axil_rd_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [N*ADDR_WIDTH-1:0] araddr;
    logic [N*3-1:0]          arprot;
    logic [N-1:0]            arvalid;
    logic [N-1:0]            arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [N-1:0]            rvalid;
    logic [N-1:0]            rready;

    // Side issuing read requests.
    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    // Side answering read requests.
    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_rd_arbiter.sv
// Round-robin N-to-1 arbiter for the AXI4-lite read path.
// One read is outstanding downstream at a time; the R beat is steered back
// to the port that owns the grant. The port served last gets lowest priority.
module axil_rd_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,      // asynchronous, active-low
    axil_rd_arbiter_if.slave           s_axil,   // upstream masters (N = S_COUNT)
    axil_rd_arbiter_if.master          m_axil,   // downstream slave (N = 1)
    output logic [$clog2(S_COUNT)-1:0] grant,
    output logic                       busy,
    output logic [1:0]                 state     // debug view of the FSM
);
    localparam int GW = $clog2(S_COUNT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [S_COUNT-1:0] ONE = S_COUNT'(1);

    logic [1:0]            state_q;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [2:0]            ar_prot_q;
    logic                  ar_valid_q;

    logic                  sel_valid;
    logic [GW-1:0]         sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [2:0]            sel_prot;
    int                    idx;

    logic                  accept;
    logic                  r_done;

    // Round-robin pick: first requesting port scanning cyclically from last+1.
    // The scan runs from the farthest candidate back to the nearest so the
    // nearest requester overwrites the others.
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        sel_addr  = '0;
        sel_prot  = '0;
        idx       = 0;
        for (int k = S_COUNT; k >= 1; k--) begin
            idx = (int'(last_q) + k) % S_COUNT;
            if (s_axil.arvalid[GW'(idx)]) begin
                sel_valid = 1'b1;
                sel       = GW'(idx);
                sel_addr  = ADDR_WIDTH'(s_axil.araddr >> (idx * ADDR_WIDTH));
                sel_prot  = 3'(s_axil.arprot >> (idx * 3));
            end
        end
    end

    // Handshake qualifiers; reset forces every ready/valid low even though
    // the combinational paths would otherwise see state IDLE.
    always_comb begin
        accept = rst && (state_q == IDLE) && sel_valid;
        r_done = (state_q == RESP) && m_axil.rvalid[0] && s_axil.rready[grant_q];
    end

    // Upstream-facing outputs: one-hot AR ready in IDLE, steered R valid in RESP.
    always_comb begin
        s_axil.arready = accept ? (ONE << sel) : '0;
        s_axil.rvalid  = ((state_q == RESP) && m_axil.rvalid[0]) ? (ONE << grant_q) : '0;
        s_axil.rdata   = m_axil.rdata;
        s_axil.rresp   = m_axil.rresp;
    end

    // Downstream-facing outputs: registered AR channel, R ready follows the owner.
    always_comb begin
        m_axil.araddr    = ar_addr_q;
        m_axil.arprot    = ar_prot_q;
        m_axil.arvalid   = ar_valid_q;
        m_axil.rready[0] = (state_q == RESP) ? s_axil.rready[grant_q] : 1'b0;
    end

    // Status outputs.
    always_comb begin
        grant = grant_q;
        busy  = (state_q != IDLE);
        state = state_q;
    end

    // FSM: IDLE accepts one request, ADDR issues it downstream, RESP returns the beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= GW'(S_COUNT - 1);
            ar_addr_q  <= '0;
            ar_prot_q  <= '0;
            ar_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ar_addr_q  <= sel_addr;
                        ar_prot_q  <= sel_prot;
                        ar_valid_q <= 1'b1;
                        grant_q    <= sel;
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axil.arready[0]) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (r_done) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ar_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Directed bench for axil_rd_arbiter (4 ports, 32-bit data/address).
// Inputs change 1 time unit after the falling edge; outputs are checked
// right after that, well away from the rising edge.
module tb_axil_rd_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       busy;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_q[$];

    axil_rd_arbiter_if #(.N(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) s_if ();
    axil_rd_arbiter_if #(.N(1), .DATA_WIDTH(32), .ADDR_WIDTH(32)) m_if ();

    axil_rd_arbiter #(.S_COUNT(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axil (s_if),
        .m_axil (m_if),
        .grant  (grant),
        .busy   (busy),
        .state  (state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] addr);
        s_if.araddr[p*32 +: 32] = addr;
        s_if.arvalid[p[1:0]]    = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        s_if.arvalid  = 4'hF;
        m_if.arready  = 1'b0;
        m_if.rvalid   = 1'b0;
        s_if.rready   = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state",   64'(state),          64'(0));
        check("rst_grant",   64'(grant),          64'(0));
        check("rst_busy",    64'(busy),           64'(0));
        check("rst_arready", 64'(s_if.arready),   64'(0));
        check("rst_arvalid", 64'(m_if.arvalid),   64'(0));
        check("rst_araddr",  64'(m_if.araddr),    64'(0));
        check("rst_arprot",  64'(m_if.arprot),    64'(0));
        check("rst_rvalid",  64'(s_if.rvalid),    64'(0));
        check("rst_rready",  64'(m_if.rready),    64'(0));
        s_if.arvalid = 4'h0;
        rst          = 1'b1;
    endtask

    // One full transaction for port p, called just after a falling edge with
    // requests already driven. ar_wait/r_wait stall the downstream AR ready
    // and the upstream R ready for that many cycles.
    task automatic xact(input int p, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input int ar_wait, input int r_wait,
                        input bit clear_req);
        #1;
        check("idle_arready", 64'(s_if.arready), 64'(1) << p);
        check("idle_busy",    64'(busy),         64'(0));
        @(negedge clk);
        if (clear_req) s_if.arvalid[p[1:0]] = 1'b0;
        for (int c = 0; c <= ar_wait; c++) begin
            #1;
            check("addr_arvalid", 64'(m_if.arvalid), 64'(1));
            check("addr_araddr",  64'(m_if.araddr),  64'(addr));
            check("addr_arprot",  64'(m_if.arprot),  64'(p));
            check("addr_grant",   64'(grant),        64'(p));
            check("addr_arready", 64'(s_if.arready), 64'(0));
            check("addr_busy",    64'(busy),         64'(1));
            if (c == ar_wait) m_if.arready = 1'b1;
            @(negedge clk);
        end
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b1;
        m_if.rdata   = data;
        m_if.rresp   = resp;
        for (int c = 0; c <= r_wait; c++) begin
            s_if.rready = (c == r_wait) ? 4'(1 << p) : ~4'(1 << p);
            #1;
            check("resp_rvalid",  64'(s_if.rvalid),  64'(1) << p);
            check("resp_rdata",   64'(s_if.rdata),   64'(data));
            check("resp_rresp",   64'(s_if.rresp),   64'(resp));
            check("resp_rready",  64'(m_if.rready),  64'(c == r_wait));
            check("resp_arvalid", 64'(m_if.arvalid), 64'(0));
            check("resp_arready", 64'(s_if.arready), 64'(0));
            @(negedge clk);
        end
        m_if.rvalid = 1'b0;
        m_if.rdata  = 32'h0;
        m_if.rresp  = 2'd0;
        s_if.rready = 4'h0;
        #1;
        check("done_state", 64'(state), 64'(0));
        check("done_busy",  64'(busy),  64'(0));
        check("done_grant", 64'(grant), 64'(p));
    endtask

    initial begin
        rst          = 1'b0;
        s_if.araddr  = '0;
        s_if.arprot  = {3'd3, 3'd2, 3'd1, 3'd0};   // port i drives prot = i
        s_if.arvalid = 4'h0;
        s_if.rready  = 4'h0;
        m_if.arready = 1'b0;
        m_if.rdata   = 32'h0;
        m_if.rresp   = 2'd0;
        m_if.rvalid  = 1'b0;
        do_reset();

        // 1: port 2 alone
        @(negedge clk);
        set_req(2, 32'h0000_1000);
        xact(2, 32'h0000_1000, 32'hDEAD_BEEF, 2'd0, 0, 0, 1'b1);

        // 2: all ports request continuously from reset
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 32'h0000_2000 + 32'(i) * 32'h100);
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        while (exp_q.size() > 0) begin
            logic [1:0] p;
            p = exp_q.pop_front();
            xact(int'(p), 32'h0000_2000 + 32'(p) * 32'h100, 32'hA000_0000 + 32'(p), 2'd0, 0, 0, 1'b0);
        end
        s_if.arvalid = 4'h0;

        // 3 and 4: downstream AR stall of 5 cycles, upstream R stall of 3 cycles,
        // with port 2 requesting in the background (last = 0, so port 1 first)
        set_req(1, 32'h0000_3004);
        set_req(2, 32'h0000_3008);
        xact(1, 32'h0000_3004, 32'h1234_5678, 2'd0, 5, 3, 1'b1);
        xact(2, 32'h0000_3008, 32'h8765_4321, 2'd0, 0, 0, 1'b1);

        // 5: reset during RESP, port 1 still requesting
        set_req(3, 32'h0000_4000);
        @(negedge clk);
        s_if.arvalid[3] = 1'b0;
        set_req(1, 32'h0000_4100);
        m_if.arready = 1'b1;
        @(negedge clk);
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b1;
        m_if.rdata   = 32'hCAFE_F00D;
        #1;
        check("mid_state", 64'(state), 64'(2));
        check("mid_grant", 64'(grant), 64'(3));
        rst = 1'b0;
        #1;
        check("arst_state",   64'(state),        64'(0));
        check("arst_busy",    64'(busy),         64'(0));
        check("arst_grant",   64'(grant),        64'(0));
        check("arst_arready", 64'(s_if.arready), 64'(0));
        check("arst_rvalid",  64'(s_if.rvalid),  64'(0));
        check("arst_rready",  64'(m_if.rready),  64'(0));
        check("arst_arvalid", 64'(m_if.arvalid), 64'(0));
        @(negedge clk);
        m_if.rvalid = 1'b0;
        m_if.rdata  = 32'h0;
        rst         = 1'b1;
        xact(1, 32'h0000_4100, 32'h0BAD_CAFE, 2'd0, 0, 0, 1'b1);

        // 6: port 3 served, then ports 1 and 3 request: port 1 wins, SLVERR passes
        set_req(3, 32'h0000_5300);
        xact(3, 32'h0000_5300, 32'h5555_0003, 2'd0, 0, 0, 1'b1);
        set_req(1, 32'h0000_5100);
        set_req(3, 32'h0000_5304);
        xact(1, 32'h0000_5100, 32'h5555_0001, 2'd2, 0, 0, 1'b1);
        xact(3, 32'h0000_5304, 32'h5555_0013, 2'd0, 0, 0, 1'b1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axil_rd_arbiter.md
Name: axil_rd_arbiter

Overview:
N-to-1 round-robin arbiter for the AXI4-lite read path (AR/R channels). Sits between S_COUNT upstream AXI-lite read masters and one downstream AXI-lite slave port. Allows exactly one read outstanding downstream at a time. Routes the R response back to the requester that owns the grant.

Parameters:
S_COUNT, 4, number of upstream ports (2..16)
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 32, address width in bits

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
s_axil_araddr  input  S_COUNT*ADDR_WIDTH  per-port AR address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
s_axil_arprot  input  S_COUNT*3  per-port AR prot
s_axil_arvalid  input  S_COUNT  per-port AR valid
s_axil_arready  output  S_COUNT  per-port AR ready
s_axil_rdata  output  DATA_WIDTH  R data, broadcast to all ports
s_axil_rresp  output  2  R resp, broadcast to all ports
s_axil_rvalid  output  S_COUNT  per-port R valid
s_axil_rready  input  S_COUNT  per-port R ready
m_axil_araddr  output  ADDR_WIDTH  downstream AR address
m_axil_arprot  output  3  downstream AR prot
m_axil_arvalid  output  1  downstream AR valid
m_axil_arready  input  1  downstream AR ready
m_axil_rdata  input  DATA_WIDTH  downstream R data
m_axil_rresp  input  2  downstream R resp
m_axil_rvalid  input  1  downstream R valid
m_axil_rready  output  1  downstream R ready
grant  output  $clog2(S_COUNT)  index of the port holding the grant
busy  output  1  high whenever state is not IDLE

Behaviour:
- FSM states: IDLE, ADDR, RESP.
- Reset (rst=0, async): state=IDLE; grant=0; last pointer=S_COUNT-1, so port 0 has first priority; m_axil_arvalid=0; m_axil_araddr=0; m_axil_arprot=0; busy=0. All s_axil_arready, s_axil_rvalid and m_axil_rready are 0 while in reset.
- IDLE:
  - Selection: the first port with arvalid=1, searching cyclically from last+1.
  - s_axil_arready[sel]=1 combinationally in the same cycle; all other arready bits are 0.
  - On that handshake: register araddr/arprot of sel into the m_axil_ar* registers, set grant=sel, go to ADDR.
  - With no request, stay in IDLE with all arready=0.
- ADDR:
  - m_axil_arvalid=1; address and prot held stable.
  - On m_axil_arready=1: clear arvalid, go to RESP.
  - All s_axil_arready=0.
- RESP:
  - m_axil_rready = s_axil_rready[grant].
  - s_axil_rvalid[grant] = m_axil_rvalid; all other rvalid bits are 0.
  - rdata/rresp pass through combinationally.
  - On m_axil_rvalid && m_axil_rready: last=grant, go to IDLE.
- Outside RESP: m_axil_rready=0 and all s_axil_rvalid=0.
- Latency:
  - Upstream AR handshake to m_axil_arvalid: 1 cycle.
  - R path: 0 cycles.
  - Minimum of 3 cycles per transaction; the next upstream accept can occur in the IDLE cycle directly after the R handshake.
- Fairness: a port that was just served has lowest priority next. A continuously requesting port waits at most S_COUNT-1 transactions.
- grant holds its value after returning to IDLE until the next accept.
- Upstream AXI rules are respected: arvalid/araddr of a non-granted port may stay asserted indefinitely without side effects.
- Reset mid-transaction: FSM returns to IDLE immediately and any in-flight response is dropped. The downstream slave shares the same reset, so no stray R beat arrives after reset.
- Unknown or out-of-range grant values cannot occur. grant < S_COUNT always.

Test Plan:
1. Port 2 only: araddr=0x1000 -> arready[2] high in cycle 0; m_araddr=0x1000 with arvalid in cycle 1; slave returns rdata=0xDEADBEEF, rresp=0 -> only s_rvalid[2] high, data delivered, busy drops.
2. All 4 ports request continuously from reset -> grant order 0,1,2,3,0; each port is served once per 4 transactions.
3. m_axil_arready held low for 5 cycles -> m_arvalid and araddr stable for 5 cycles; no arready to any port until the transaction completes.
4. m_rvalid=1 with s_rready[grant]=0 for 3 cycles -> m_rready=0, rvalid/rdata held; completes on the cycle s_rready rises.
5. rst driven low during RESP -> next cycle state=IDLE, busy=0, all valids/readies 0, grant=0; after reset release a port-1 request is accepted normally.
6. Ports 1 and 3 request after a port-3 transaction (last=3) -> port 1 is granted before port 3; an SLVERR (rresp=2) response is passed through unmodified to port 1.
